// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_if
// Description : Bundle of the writeback arbiter's result-source and
//               register-file write signals.
//               Source side (ALU): alu_valid, alu_rd, alu_data -> alu_stall
//               Source side (LSU): lsu_valid, lsu_rd, lsu_data -> lsu_ready
//               Register file    : rd_addr, rd_data, rd_wen
//               Decode interlock : busy_mask
//               modport master : the pipeline side (drives the sources)
//               modport slave  : the arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wen;
  logic [31:0] busy_mask;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_stall, lsu_ready, rd_addr, rd_data, rd_wen, busy_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_stall, lsu_ready, rd_addr, rd_data, rd_wen, busy_mask
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter for the single register-file write port.
//               Merges the single-cycle ALU path and the buffered, in-order
//               LSU path into at most one registered write per cycle. A
//               starvation counter forces an LSU slot after STARVE_MAX
//               consecutive ALU wins while LSU results are waiting.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               bus        - wb_arbiter_if.slave (sources, write port,
//                            busy mask)
// Parameters  : DEPTH      - LSU result FIFO entries (power of two, >= 2)
//               STARVE_MAX - ALU wins allowed while the FIFO is non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  wb_arbiter_if.slave   bus
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam int C_STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [C_CNT_W-1:0] C_DEPTH      = C_CNT_W'(DEPTH);
  localparam logic [C_STV_W-1:0] C_STARVE_MAX = C_STV_W'(STARVE_MAX);

  // FIFO storage; the per-slot valid bits feed the busy mask directly
  logic [4:0]         r_mem_rd   [DEPTH];
  logic [31:0]        r_mem_data [DEPTH];
  logic [DEPTH-1:0]   r_slot_vld;
  logic [C_PTR_W-1:0] r_head;
  logic [C_PTR_W-1:0] r_tail;
  logic [C_CNT_W-1:0] r_count;
  logic [C_STV_W-1:0] r_starve;

  logic [4:0]         r_rd_addr;
  logic [31:0]        r_rd_data;
  logic               r_rd_wen;

  logic               w_empty;
  logic               w_alu_req;
  logic               w_alu_win;
  logic               w_pop;
  logic               w_lsu_ready;
  logic               w_push;
  logic [31:0]        w_busy;

  assign w_empty     = (r_count == '0);
  assign w_alu_req   = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign w_alu_win   = w_alu_req && (w_empty || (r_starve < C_STARVE_MAX));
  assign w_pop       = !w_alu_win && !w_empty;
  // Depends only on the current count: no pass-through when full
  assign w_lsu_ready = !rst && (r_count < C_DEPTH);
  // Transfers to x0 are acknowledged but never stored
  assign w_push      = bus.lsu_valid && w_lsu_ready && (bus.lsu_rd != 5'd0);

  assign bus.lsu_ready = w_lsu_ready;
  assign bus.alu_stall = !rst && w_alu_req && !w_empty && (r_starve == C_STARVE_MAX);
  assign bus.rd_addr   = r_rd_addr;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_wen    = r_rd_wen;

  // FIFO payload carries no reset: stale slots are masked by r_slot_vld
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_tail]   <= bus.lsu_rd;
      r_mem_data[r_tail] <= bus.lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_slot_vld <= '0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
      r_rd_wen   <= 1'b0;
    end else begin
      // Push and pop never target the same slot: that would need the FIFO
      // to be both empty (pop) and full (push) at once.
      if (w_push) begin
        r_slot_vld[r_tail] <= 1'b1;
        r_tail             <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_slot_vld[r_head] <= 1'b0;
        r_head             <= r_head + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // The counter only moves while LSU results are waiting; an ALU win
      // with a non-empty FIFO implies r_starve < STARVE_MAX, so the
      // increment saturates by construction.
      if (w_pop || w_empty) begin
        r_starve <= '0;
      end else if (w_alu_win) begin
        r_starve <= r_starve + 1'b1;
      end

      if (w_alu_win) begin
        r_rd_addr <= bus.alu_rd;
        r_rd_data <= bus.alu_data;
        r_rd_wen  <= 1'b1;
      end else if (w_pop) begin
        r_rd_addr <= r_mem_rd[r_head];
        r_rd_data <= r_mem_data[r_head];
        r_rd_wen  <= 1'b1;
      end else begin
        r_rd_wen  <= 1'b0;
      end
    end
  end

  // Pending writes: every queued entry plus the write being presented now
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_slot_vld[i]) begin
        w_busy[r_mem_rd[i]] = 1'b1;
      end
    end
    if (r_rd_wen) begin
      w_busy[r_rd_addr] = 1'b1;
    end
    w_busy[0] = 1'b0;
    bus.busy_mask = rst ? 32'd0 : w_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter. Each scenario task drives
//               the sources and checks handshake/busy outputs inline; every
//               expected register write is queued on a scoreboard in the
//               order it must appear, and a write monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  logic clk;
  logic rst;

  wb_arbiter_if bus ();

  wb_arbiter #(
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Expected writes as {rd, data}, in required order
  logic [36:0] sb_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Write monitor: every presented write must match the scoreboard head
  always @(negedge clk) begin
    if (bus.rd_wen === 1'b1) begin
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_write: got rd=%0d data=%08h, required no write",
                 bus.rd_addr, bus.rd_data);
      end else begin
        logic [36:0] exp_w;
        exp_w = sb_q.pop_front();
        if ({bus.rd_addr, bus.rd_data} !== exp_w)
          $display("FAIL sb_write: got rd=%0d data=%08h, required rd=%0d data=%08h",
                   bus.rd_addr, bus.rd_data, exp_w[36:32], exp_w[31:0]);
        else
          n_pass++;
      end
    end
  end

  task automatic drive_idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'd0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = 5'd0;
    bus.lsu_data  = 32'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_idle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h1111_1111;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h2222_2222;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_total++; if (bus.rd_wen !== 1'b0) $display("FAIL reset_rd_wen: got %0b required 0", bus.rd_wen); else n_pass++;
      n_total++; if (bus.lsu_ready !== 1'b0) $display("FAIL reset_lsu_ready: got %0b required 0", bus.lsu_ready); else n_pass++;
      n_total++; if (bus.busy_mask !== 32'd0) $display("FAIL reset_busy_mask: got %08h required 0", bus.busy_mask); else n_pass++;
      n_total++; if (bus.alu_stall !== 1'b0) $display("FAIL reset_alu_stall: got %0b required 0", bus.alu_stall); else n_pass++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    n_total++; if (bus.lsu_ready !== 1'b1) $display("FAIL release_lsu_ready: got %0b required 1", bus.lsu_ready); else n_pass++;
    n_total++; if (bus.rd_addr !== 5'd0 || bus.rd_data !== 32'd0) $display("FAIL release_rd_regs: got rd=%0d data=%08h required 0/0", bus.rd_addr, bus.rd_data); else n_pass++;
    idle(1);
  endtask

  task automatic test_alu_lone();
    @(posedge clk); #1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    sb_q.push_back({5'd5, 32'hDEAD_BEEF});
    @(negedge clk);
    n_total++; if (bus.alu_stall !== 1'b0) $display("FAIL alu_lone_stall: got %0b required 0", bus.alu_stall); else n_pass++;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_total++; if (bus.rd_wen !== 1'b1 || bus.rd_addr !== 5'd5 || bus.rd_data !== 32'hDEAD_BEEF)
      $display("FAIL alu_lone_write: got wen=%0b rd=%0d data=%08h required 1/5/deadbeef", bus.rd_wen, bus.rd_addr, bus.rd_data);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_lsu_lone();
    @(posedge clk); #1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_1234;
    @(negedge clk);
    n_total++; if (bus.lsu_ready !== 1'b1) $display("FAIL lsu_lone_ready: got %0b required 1", bus.lsu_ready); else n_pass++;
    @(posedge clk); #1;
    drive_idle();
    sb_q.push_back({5'd7, 32'h0000_1234});
    @(negedge clk);
    n_total++; if (bus.busy_mask !== 32'h0000_0080) $display("FAIL lsu_lone_busy_t1: got %08h required 00000080", bus.busy_mask); else n_pass++;
    n_total++; if (bus.rd_wen !== 1'b0) $display("FAIL lsu_lone_wen_t1: got %0b required 0", bus.rd_wen); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (bus.rd_wen !== 1'b1 || bus.rd_addr !== 5'd7) $display("FAIL lsu_lone_write_t2: got wen=%0b rd=%0d required 1/7", bus.rd_wen, bus.rd_addr); else n_pass++;
    n_total++; if (bus.busy_mask !== 32'h0000_0080) $display("FAIL lsu_lone_busy_t2: got %08h required 00000080", bus.busy_mask); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (bus.busy_mask !== 32'd0) $display("FAIL lsu_lone_busy_t3: got %08h required 0", bus.busy_mask); else n_pass++;
    idle(2);
  endtask

  task automatic test_starvation();
    logic [31:0] d;
    int          i;
    logic        exp_stall;
    i = 0;
    @(posedge clk); #1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h0000_0099;
    @(negedge clk);
    n_total++; if (bus.lsu_ready !== 1'b1) $display("FAIL starve_lsu_ready: got %0b required 1", bus.lsu_ready); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
      d = 32'hA000_0000 + 32'(i);
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = d;
      exp_stall = (k == 4);
      if (exp_stall) begin
        sb_q.push_back({5'd9, 32'h0000_0099});
      end else begin
        sb_q.push_back({5'd1, d});
        i++;
      end
      @(negedge clk);
      n_total++; if (bus.alu_stall !== exp_stall) $display("FAIL starve_stall_k%0d: got %0b required %0b", k, bus.alu_stall, exp_stall); else n_pass++;
      if (k == 5) begin
        n_total++; if (bus.rd_wen !== 1'b1 || bus.rd_addr !== 5'd9) $display("FAIL starve_forced_slot: got wen=%0b rd=%0d required 1/9", bus.rd_wen, bus.rd_addr); else n_pass++;
      end
    end
    idle(3);
  endtask

  task automatic test_full_fifo();
    logic [15:0] rdy_tab;
    logic [15:0] stall_tab;
    logic [36:0] lsu_exp [$];
    logic [31:0] d;
    int          i;
    int          j;
    rdy_tab   = 16'b1111_1000_0100_0011;
    stall_tab = 16'b1000_0100_0010_0000;
    i = 0;
    j = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (j < 3) begin
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'(2 + j);
        bus.lsu_data  = 32'h0000_0200 + 32'(j * 256);
      end else begin
        bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
      end
      d = 32'hB000_0000 + 32'(i);
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = d;
      if (stall_tab[k]) begin
        sb_q.push_back(lsu_exp.pop_front());
      end else begin
        sb_q.push_back({5'd10, d});
        i++;
      end
      @(negedge clk);
      n_total++; if (bus.lsu_ready !== rdy_tab[k]) $display("FAIL full_ready_c%0d: got %0b required %0b", k, bus.lsu_ready, rdy_tab[k]); else n_pass++;
      n_total++; if (bus.alu_stall !== stall_tab[k]) $display("FAIL full_stall_c%0d: got %0b required %0b", k, bus.alu_stall, stall_tab[k]); else n_pass++;
      if (k == 2) begin
        n_total++; if (bus.busy_mask !== 32'h0000_040C) $display("FAIL full_busy_c2: got %08h required 0000040c", bus.busy_mask); else n_pass++;
      end
      if (bus.lsu_valid && rdy_tab[k]) begin
        lsu_exp.push_back({bus.lsu_rd, bus.lsu_data});
        j++;
      end
    end
    idle(3);
  endtask

  task automatic test_zero_reg();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hCAFE_0000;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hCAFE_0001;
      @(negedge clk);
      n_total++; if (bus.alu_stall !== 1'b0) $display("FAIL zero_stall_c%0d: got %0b required 0", k, bus.alu_stall); else n_pass++;
      n_total++; if (bus.lsu_ready !== 1'b1) $display("FAIL zero_ready_c%0d: got %0b required 1", k, bus.lsu_ready); else n_pass++;
      n_total++; if (bus.busy_mask !== 32'd0) $display("FAIL zero_busy_c%0d: got %08h required 0", k, bus.busy_mask); else n_pass++;
      n_total++; if (bus.rd_wen !== 1'b0) $display("FAIL zero_wen_c%0d: got %0b required 0", k, bus.rd_wen); else n_pass++;
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 32'h0000_000B;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd13; bus.alu_data = 32'h0000_00D0;
    sb_q.push_back({5'd13, 32'h0000_00D0});
    @(posedge clk); #1;
    bus.lsu_rd = 5'd12; bus.lsu_data = 32'h0000_000C;
    bus.alu_data = 32'h0000_00D1;
    sb_q.push_back({5'd13, 32'h0000_00D1});
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    n_total++; if (bus.rd_wen !== 1'b1) $display("FAIL mid_pre_reset_wen: got %0b required 1", bus.rd_wen); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.rd_wen !== 1'b0) $display("FAIL mid_post_wen: got %0b required 0", bus.rd_wen); else n_pass++;
    n_total++; if (bus.busy_mask !== 32'd0) $display("FAIL mid_post_busy: got %08h required 0", bus.busy_mask); else n_pass++;
    n_total++; if (bus.lsu_ready !== 1'b1) $display("FAIL mid_post_ready: got %0b required 1", bus.lsu_ready); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_total++; if (bus.rd_wen !== 1'b0) $display("FAIL mid_discard_c%0d: got wen=%0b rd=%0d required 0", k, bus.rd_wen, bus.rd_addr); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_alu_lone();
    test_lsu_lone();
    test_starvation();
    test_full_fifo();
    test_zero_reg();
    test_reset_mid();
    idle(2);
    n_total++;
    if (sb_q.size() != 0) $display("FAIL sb_drained: got %0d outstanding writes required 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that drives the single write port of the core's 32×32 register file (rd_addr / rd_data / rd_wen). It merges two result sources, the single-cycle ALU path and the variable-latency load/store path (LSU), into at most one register write per cycle. LSU results are buffered in a small in-order FIFO. A starvation counter guarantees LSU forward progress by stalling the ALU. A busy mask exposes registers with writes in flight so decode can interlock.

## Interface
- DEPTH, 2: LSU result FIFO entries (power of two, ≥2).
- STARVE_MAX, 4: consecutive ALU wins allowed while the FIFO is non-empty before the ALU is stalled.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  ALU result not consumed this cycle; upstream holds alu_valid/alu_rd/alu_data unchanged.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  FIFO can accept; a transfer occurs when lsu_valid && lsu_ready.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  32  LSU result.
- rd_addr  out  5  register file write address (registered).
- rd_data  out  32  register file write data (registered).
- rd_wen  out  1  register file write enable (registered).
- busy_mask  out  32  bit r = 1 while a write to register r is pending inside this block.

## Operation
- ALU request = alu_valid && alu_rd != 0. alu_valid with alu_rd == 0 is consumed silently: no write, no stall, no effect on the starvation counter.
- LSU push: on transfer with lsu_rd != 0, append {lsu_rd, lsu_data} at the FIFO tail. A transfer with lsu_rd == 0 is acknowledged and discarded.
- lsu_ready = !rst && count < DEPTH. It depends only on the current count, so there is no pass-through when full, even if a pop occurs the same cycle.
- Selection, each cycle:
  - If there is an ALU request and (FIFO empty or starve_cnt < STARVE_MAX), the ALU wins.
  - Otherwise, if the FIFO is non-empty, the FIFO head wins and is popped.
  - Otherwise there is no write.
- alu_stall = ALU request && FIFO non-empty && starve_cnt == STARVE_MAX. It is combinational and 0 during rst.
- starve_cnt:
  - +1, saturating at STARVE_MAX, when the ALU wins while the FIFO is non-empty.
  - Cleared to 0 on any FIFO pop or whenever the FIFO is empty.
- Output stage: the winner's rd/data are registered into rd_addr/rd_data with rd_wen = 1. With no winner, rd_wen = 0 and rd_addr/rd_data hold their previous values.
- Ordering:
  - The FIFO is strictly in-order.
  - There is no ordering between the ALU and the LSU. Decode must not issue an ALU op whose rd has its busy_mask bit set (WAW interlock).
- busy_mask = OR over valid FIFO entries of (1 << rd), ORed with (rd_wen ? 1 << rd_addr : 0). Combinational from registered state; bit 0 is always 0.
- Push and pop in the same cycle leave count unchanged. Head and tail pointers wrap modulo DEPTH.
- Reset (any cycle, including mid-operation):
  - FIFO is emptied and its contents are discarded; count = 0, starve_cnt = 0.
  - rd_wen = 0, rd_addr = 0, rd_data = 0.
  - busy_mask = 0, lsu_ready = 0 while rst is high, alu_stall = 0.
  - No write issues in the cycle after reset is released unless selected in that cycle.

## Timing
- ALU latency: request in cycle t gives rd_wen = 1 with rd_addr = alu_rd from the rising edge ending cycle t, visible in cycle t+1.
- LSU latency: transfer in t, entry is in the FIFO in t+1; if it wins in t+1, rd_wen is visible in t+2. The minimum is 2 cycles.
- Throughput: 1 write per cycle.
- Worst-case wait for the FIFO head under continuous ALU traffic is STARVE_MAX cycles, then 1 forced LSU slot.
- lsu_ready rises the cycle after a pop frees an entry.
- busy_mask bit r is set from the cycle after the push and clears the cycle after the register write is presented (rd_wen dropped or a different rd_addr).

## Test plan
- Reset: hold rst 3 cycles with lsu_valid = alu_valid = 1 -> rd_wen = 0, lsu_ready = 0, busy_mask = 0, alu_stall = 0. Release -> lsu_ready = 1 the next cycle.
- Lone sources:
  - ALU rd = 5, data = 0xDEADBEEF in t -> rd_wen = 1, rd_addr = 5, rd_data = 0xDEADBEEF in t+1.
  - LSU rd = 7, data = 0x1234 accepted in t -> busy_mask[7] = 1 in t+1; write visible in t+2; busy_mask[7] = 0 in t+3.
- Starvation (STARVE_MAX = 4): LSU rd = 9 queued, ALU valid every cycle (rd = 1) -> 4 ALU writes, then alu_stall = 1 for one cycle with rd_addr = 9 written next, then ALU resumes. starve_cnt restarts only if a second entry is queued.
- Full FIFO: push 3 LSU results back-to-back (rd = 2, 3, 4) under constant ALU traffic -> lsu_ready = 0 after 2 accepts. The 3rd is accepted only after a pop. Writes occur in order 2, 3, 4.
- Zero register: ALU rd = 0 and LSU rd = 0 -> no rd_wen, no FIFO growth, busy_mask[0] = 0, no stall.
- Reset mid-operation: 2 entries queued and rd_wen = 1, assert rst one cycle -> next cycle rd_wen = 0 and busy_mask = 0. The queued results are never written.
